// File: rtl/regfile_pkg.sv
// regfile_pkg: write-op encodings shared by the register bank and its op unit
package regfile_pkg;
  typedef enum logic [1:0] {
    WOP_LOAD = 2'b00,
    WOP_INC  = 2'b01,
    WOP_DEC  = 2'b10,
    WOP_CLR  = 2'b11
  } wop_t;
endpackage

// File: rtl/regn_op_unit.sv
// regn_op_unit: combinational write-op ALU computing the new register value and carry/borrow
// ports: op (write op), cur (current register value), wdata (load data) -> result, cout
module regn_op_unit
  import regfile_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  wop_t             op,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] result,
  output logic             cout
);
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;
  // One extra bit: carry on INC, and borrow on DEC (0-1 sets the top bit)
  assign inc = {1'b0, cur} + (WIDTH+1)'(1);
  assign dec = {1'b0, cur} - (WIDTH+1)'(1);
  always_comb begin
    result = op == WOP_LOAD ? wdata : op == WOP_INC ? inc[WIDTH-1:0] : op == WOP_DEC ? dec[WIDTH-1:0] : '0;
    cout   = op == WOP_INC ? inc[WIDTH] : op == WOP_DEC ? dec[WIDTH] : 1'b0;
  end
endmodule

// File: rtl/regfile_n.sv
// regfile_n: DEPTH x WIDTH register bank, one op-mode write port, two registered bypassed read ports, carry/zero flags
// ports: clk, clr_n (sync active-low reset), we/wop/waddr/wdata (write), raddr_a/raddr_b (read index)
//        -> rdata_a/rdata_b (1-cycle read data), cout/zero (flags of last accepted write)
module regfile_n
  import regfile_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             we,
  input  logic [1:0]       wop,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             cout,
  output logic             zero
);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] nxt_a;
  logic [WIDTH-1:0] nxt_b;
  logic             c;
  logic             hit;
  logic             ok_a;
  logic             ok_b;
  regn_op_unit #(.WIDTH(WIDTH)) u_op (
    .op     (wop_t'(wop)),
    .cur    (cur),
    .wdata  (wdata),
    .result (res),
    .cout   (c)
  );
  // DEPTH need not be a power of two, so every index is range-checked
  always_comb begin
    hit   = we && ({1'b0, waddr} < DEPTH_W);
    ok_a  = {1'b0, raddr_a} < DEPTH_W;
    ok_b  = {1'b0, raddr_b} < DEPTH_W;
    cur   = hit ? regs[waddr] : '0;
    nxt_a = !ok_a ? '0 : hit && waddr == raddr_a ? res : regs[raddr_a];
    nxt_b = !ok_b ? '0 : hit && waddr == raddr_b ? res : regs[raddr_b];
  end
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      regs    <= '{default: '0};
      rdata_a <= '0;
      rdata_b <= '0;
      cout    <= 1'b0;
      zero    <= 1'b0;
    end else begin
      if (hit) begin
        regs[waddr] <= res;
        cout        <= c;
        zero        <= res == '0;
      end
      rdata_a <= nxt_a;
      rdata_b <= nxt_b;
    end
  end
endmodule
